// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter
// Turns rising edges on N synchronous level inputs into pending events and
// offers them one at a time, in round-robin order, to a single consumer.
//
// Handshake: ev_valid/ev_id form the offer. Once ev_valid is high, it and
// ev_id stay unchanged until the consumer samples ev_valid & ev_ready high
// at a rising CLK edge, which is the acceptance. The next offer may follow
// on the very next cycle with no idle gap.
module edge_event_arbiter #(
  parameter int N = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic           CLK,
  input  logic           reset,
  input  logic           en,
  input  logic [N-1:0]   level,
  output logic           ev_valid,
  output logic [IDW-1:0] ev_id,
  input  logic           ev_ready,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   overflow,
  input  logic           clr_ovf
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   prev_level;
  logic [N-1:0]   rise;
  logic [N-1:0]   acc_vec;
  logic [N-1:0]   pend_left;
  logic [N-1:0]   pend_nxt;
  logic [N-1:0]   ovf_set;
  logic [N-1:0]   ovf_nxt;
  logic [IDW-1:0] rr_ptr, rr_nxt;
  logic [IDW-1:0] id_nxt;
  logic [IDW-1:0] id_inc;
  logic           acc;

  // First set bit of vec at or above start, wrapping to 0. The vector is
  // rotated so the search runs from bit 0; indices >= N cannot appear.
  function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] vec,
                                             input logic [IDW-1:0] start);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IDW-1:0] res;
    logic           found;
    int             s;
    dbl   = {vec, vec} >> start;
    rot   = dbl[N-1:0];
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        s     = int'(start) + k;
        if (s >= N) s = s - N;
        res   = IDW'(s);
      end
    end
    return res;
  endfunction

  assign ev_valid = (state == OFFER);
  assign id_inc   = (ev_id == IDW'(N - 1)) ? '0 : ev_id + IDW'(1);

  // Edge capture, acceptance decode and the pending/overflow next values.
  always_comb begin
    rise    = en ? (level & ~prev_level) : '0;
    acc     = ev_valid & ev_ready;
    acc_vec = '0;
    if (acc) acc_vec[ev_id] = 1'b1;
    // A rise on the channel being accepted re-arms it instead of being lost.
    pend_left = pending & ~acc_vec;
    pend_nxt  = pend_left | rise;
    ovf_set   = rise & pending & ~acc_vec;
    // A fresh loss in the same cycle as a clear must remain visible.
    ovf_nxt   = (clr_ovf ? '0 : overflow) | ovf_set;
  end

  // Arbiter next state: only registered pending bits are considered, so a
  // re-armed channel is queued behind every other waiting channel.
  always_comb begin
    state_nxt = state;
    id_nxt    = ev_id;
    rr_nxt    = rr_ptr;
    case (state)
      IDLE: begin
        if (|pending) begin
          id_nxt    = rr_pick(pending, rr_ptr);
          state_nxt = OFFER;
        end
      end
      OFFER: begin
        if (acc) begin
          rr_nxt = id_inc;
          if (|pend_left) begin
            id_nxt = rr_pick(pend_left, id_inc);
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset drops any offered or pending event silently.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= IDLE;
      ev_id      <= '0;
      rr_ptr     <= '0;
      prev_level <= '0;
      pending    <= '0;
      overflow   <= '0;
    end else begin
      state      <= state_nxt;
      ev_id      <= id_nxt;
      rr_ptr     <= rr_nxt;
      prev_level <= level;
      pending    <= pend_nxt;
      overflow   <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter
// Vector table, hand sequences for multi-cycle corners, then random traffic
// against a behavioural model with an expected-id queue for deliveries.
module tb_edge_event_arbiter;

  localparam int N   = 4;
  localparam int IDW = $clog2(N);

  logic           CLK = 1'b0;
  logic           reset;
  logic           en;
  logic [N-1:0]   level;
  logic           ev_valid;
  logic [IDW-1:0] ev_id;
  logic           ev_ready;
  logic [N-1:0]   pending;
  logic [N-1:0]   overflow;
  logic           clr_ovf;

  int n_checks = 0;
  int n_fail   = 0;
  logic [IDW-1:0] exp_q[$];

  typedef struct {
    logic           rst;
    logic           en;
    logic           rdy;
    logic           clr;
    logic [N-1:0]   lvl;
    logic           exp_v;
    logic [IDW-1:0] exp_id;
    logic [N-1:0]   exp_p;
    logic [N-1:0]   exp_o;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model state
  bit m_prev[N];
  bit m_pend[N];
  bit m_ovf[N];
  bit m_valid;
  int m_id;
  int m_rr;

  edge_event_arbiter #(.N(N)) dut (
    .CLK      (CLK),
    .reset    (reset),
    .en       (en),
    .level    (level),
    .ev_valid (ev_valid),
    .ev_id    (ev_id),
    .ev_ready (ev_ready),
    .pending  (pending),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  // Clock
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    en       = 1'b1;
    level    = '0;
    ev_ready = 1'b0;
    clr_ovf  = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [IDW-1:0] id,
                            input logic [N-1:0] p, input logic [N-1:0] o);
    check({tag, "_valid"}, 32'(ev_valid), 32'(v));
    if (v) check({tag, "_id"}, 32'(ev_id), 32'(id));
    check({tag, "_pending"}, 32'(pending), 32'(p));
    check({tag, "_overflow"}, 32'(overflow), 32'(o));
  endtask

  task automatic addv(input logic rst, input logic e, input logic rdy, input logic clr,
                      input logic [N-1:0] lvl, input logic v, input logic [IDW-1:0] id,
                      input logic [N-1:0] p, input logic [N-1:0] o);
    vec_t r;
    r.rst = rst; r.en = e; r.rdy = rdy; r.clr = clr; r.lvl = lvl;
    r.exp_v = v; r.exp_id = id; r.exp_p = p; r.exp_o = o;
    tbl.push_back(r);
  endtask

  function automatic int pick(input bit v[N], input int start);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (start + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] pack(input bit v[N]);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = v[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_prev[i] = 1'b0; m_pend[i] = 1'b0; m_ovf[i] = 1'b0;
    end
    m_valid = 1'b0; m_id = 0; m_rr = 0;
  endtask

  // Advance the model by one clock edge using the current inputs.
  task automatic model_step();
    bit old[N];
    bit accd;
    int a;
    int nx;
    if (reset) begin
      model_reset();
    end else begin
      accd = m_valid && ev_ready;
      a    = m_id;
      for (int i = 0; i < N; i++) old[i] = m_pend[i];
      for (int i = 0; i < N; i++) begin
        bit r, hit;
        r   = en && level[i] && !m_prev[i];
        hit = accd && (a == i);
        if (r && old[i] && !hit) m_ovf[i] = 1'b1;
        else if (clr_ovf)        m_ovf[i] = 1'b0;
        m_pend[i] = r ? 1'b1 : (hit ? 1'b0 : old[i]);
        m_prev[i] = level[i];
      end
      if (!m_valid) begin
        nx = pick(old, m_rr);
        if (nx >= 0) begin m_valid = 1'b1; m_id = nx; end
      end else if (accd) begin
        m_rr   = (a + 1) % N;
        old[a] = 1'b0;
        nx = pick(old, m_rr);
        if (nx >= 0) m_id = nx;
        else         m_valid = 1'b0;
      end
    end
  endtask

  initial begin
    do_reset();
    expect_out("reset", 1'b0, '0, '0, '0);
    check("reset_id", 32'(ev_id), 32'd0);

    // rst en rdy clr lvl      v  id  pending   overflow
    addv(0, 1, 0, 0, 4'b0100, 0, 0, 4'b0100, 4'b0000);
    addv(0, 1, 0, 0, 4'b0100, 1, 2, 4'b0100, 4'b0000);
    addv(0, 1, 0, 0, 4'b0100, 1, 2, 4'b0100, 4'b0000);
    addv(0, 1, 1, 0, 4'b0100, 0, 0, 4'b0000, 4'b0000);
    addv(0, 1, 0, 0, 4'b0100, 0, 0, 4'b0000, 4'b0000);
    addv(0, 1, 0, 0, 4'b0100, 0, 0, 4'b0000, 4'b0000);
    addv(1, 1, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    addv(0, 1, 1, 0, 4'b1011, 0, 0, 4'b1011, 4'b0000);
    addv(0, 1, 1, 0, 4'b1011, 1, 0, 4'b1011, 4'b0000);
    addv(0, 1, 1, 0, 4'b1011, 1, 1, 4'b1010, 4'b0000);
    addv(0, 1, 1, 0, 4'b1011, 1, 3, 4'b1000, 4'b0000);
    addv(0, 1, 1, 0, 4'b1011, 0, 0, 4'b0000, 4'b0000);
    addv(0, 1, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
    addv(0, 1, 0, 0, 4'b0010, 0, 0, 4'b0010, 4'b0000);
    addv(0, 1, 0, 0, 4'b0010, 1, 1, 4'b0010, 4'b0000);
    addv(0, 1, 1, 0, 4'b0010, 0, 0, 4'b0000, 4'b0000);
    addv(0, 1, 1, 0, 4'b1011, 0, 0, 4'b1001, 4'b0000);
    addv(0, 1, 1, 0, 4'b1011, 1, 3, 4'b1001, 4'b0000);
    addv(0, 1, 1, 0, 4'b1011, 1, 0, 4'b0001, 4'b0000);
    addv(0, 1, 1, 0, 4'b1011, 0, 0, 4'b0000, 4'b0000);

    for (int i = 0; i < tbl.size(); i++) begin
      reset    = tbl[i].rst;
      en       = tbl[i].en;
      ev_ready = tbl[i].rdy;
      clr_ovf  = tbl[i].clr;
      level    = tbl[i].lvl;
      step();
      expect_out($sformatf("tbl%0d", i), tbl[i].exp_v, tbl[i].exp_id, tbl[i].exp_p, tbl[i].exp_o);
      if (tbl[i].rst) check($sformatf("tbl%0d_rst_id", i), 32'(ev_id), 32'd0);
    end
    reset = 1'b0;

    // Overflow while the consumer stalls, then clear, then clear racing a set
    do_reset();
    level = 4'b0010; step(); expect_out("ovf_a", 0, 0, 4'b0010, 4'b0000);
    step();                  expect_out("ovf_b", 1, 1, 4'b0010, 4'b0000);
    level = 4'b0000; step(); expect_out("ovf_c", 1, 1, 4'b0010, 4'b0000);
    level = 4'b0010; step(); expect_out("ovf_d", 1, 1, 4'b0010, 4'b0010);
    ev_ready = 1'b1; step(); expect_out("ovf_e", 0, 0, 4'b0000, 4'b0010);
    ev_ready = 1'b0; step(); expect_out("ovf_f", 0, 0, 4'b0000, 4'b0010);
    step();                  expect_out("ovf_g", 0, 0, 4'b0000, 4'b0010);
    clr_ovf = 1'b1;  step(); expect_out("ovf_clr", 0, 0, 4'b0000, 4'b0000);
    clr_ovf = 1'b0;
    level = 4'b0000; step();
    level = 4'b0010; step(); expect_out("ovf_h", 0, 0, 4'b0010, 4'b0000);
    step();                  expect_out("ovf_i", 1, 1, 4'b0010, 4'b0000);
    level = 4'b0000; step(); expect_out("ovf_j", 1, 1, 4'b0010, 4'b0000);
    level = 4'b0010; clr_ovf = 1'b1; step();
    expect_out("ovf_setwins", 1, 1, 4'b0010, 4'b0010);
    clr_ovf = 1'b0; ev_ready = 1'b1; step();
    expect_out("ovf_k", 0, 0, 4'b0000, 4'b0010);
    ev_ready = 1'b0;

    // Re-arm on the channel being accepted
    do_reset();
    level = 4'b0001; step(); expect_out("rearm_a", 0, 0, 4'b0001, 4'b0000);
    step();                  expect_out("rearm_b", 1, 0, 4'b0001, 4'b0000);
    level = 4'b0000; step(); expect_out("rearm_c", 1, 0, 4'b0001, 4'b0000);
    level = 4'b0001; ev_ready = 1'b1; step();
    expect_out("rearm_d", 0, 0, 4'b0001, 4'b0000);
    ev_ready = 1'b0; step(); expect_out("rearm_e", 1, 0, 4'b0001, 4'b0000);
    ev_ready = 1'b1; step(); expect_out("rearm_f", 0, 0, 4'b0000, 4'b0000);
    ev_ready = 1'b0;

    // Enable masking: no capture while disabled, no late edge on enable
    do_reset();
    en = 1'b0; level = 4'b1000; step(); expect_out("en_a", 0, 0, 4'b0000, 4'b0000);
    step();                             expect_out("en_b", 0, 0, 4'b0000, 4'b0000);
    en = 1'b1; step();                  expect_out("en_c", 0, 0, 4'b0000, 4'b0000);
    step();                             expect_out("en_d", 0, 0, 4'b0000, 4'b0000);

    // Reset in the middle of an offer
    do_reset();
    level = 4'b0011; step(); expect_out("rst_a", 0, 0, 4'b0011, 4'b0000);
    step();                  expect_out("rst_b", 1, 0, 4'b0011, 4'b0000);
    reset = 1'b1; step();    expect_out("rst_c", 0, 0, 4'b0000, 4'b0000);
    check("rst_c_id", 32'(ev_id), 32'd0);
    reset = 1'b0; step();    expect_out("rst_d", 0, 0, 4'b0011, 4'b0000);
    step();                  expect_out("rst_e", 1, 0, 4'b0011, 4'b0000);

    // Random traffic against the model
    do_reset();
    model_reset();
    exp_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check("rnd_valid", 32'(ev_valid), 32'(m_valid));
      if (m_valid) check("rnd_id", 32'(ev_id), 32'(m_id));
      check("rnd_pending", 32'(pending), 32'(pack(m_pend)));
      check("rnd_overflow", 32'(overflow), 32'(pack(m_ovf)));

      reset    = ($urandom_range(0, 199) == 0);
      en       = ($urandom_range(0, 9) != 0);
      ev_ready = 1'($urandom_range(0, 1));
      clr_ovf  = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 3) == 0) level[i] = ~level[i];

      if (m_valid && ev_ready && !reset) exp_q.push_back(IDW'(m_id));
      if (ev_valid && ev_ready && !reset) begin
        check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("sb_id", 32'(ev_id), 32'(exp_q.pop_front()));
      end

      model_step();
      step();
    end
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Watches N asynchronous-free, clock-synchronous level inputs (buttons, status lines).
- Detects each rising edge and latches it as a pending event.
- Shares one downstream event consumer between the N channels with round-robin arbitration over a valid/ready handshake.
- Sits between the per-input level sources and the single command/decode stage that services one event at a time.

Parameters:
- N, 4, number of level channels; legal range 2..16.
- IDW, $clog2(N), width of ev_id; derived, not overridden.

Ports:
- CLK  input  1  system clock, all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  edge capture enable; 0 masks new edges, prev_level still tracks.
- level  input  N  level inputs, already synchronous to CLK.
- ev_valid  output  1  event offered to consumer.
- ev_id  output  IDW  channel index of offered event.
- ev_ready  input  1  consumer accepts event when ev_valid & ev_ready at posedge.
- pending  output  N  per-channel pending flags (status).
- overflow  output  N  sticky per-channel lost-event flags.
- clr_ovf  input  1  one-cycle pulse, clears all overflow bits.

Behaviour:
- Reset, sampled on posedge:
  - prev_level=0, pending=0, overflow=0, ev_valid=0, ev_id=0, rr_ptr=0, state=IDLE.
  - prev_level resets to 0, so a level already high at reset release yields one event.
- Edge detect per channel i: rise[i] = en & level[i] & ~prev_level[i] (combinational). prev_level <= level every cycle regardless of en.
- Accept: acc = ev_valid & ev_ready; acc_i = acc & (ev_id==i).
- Pending update per channel:
  - rise[i] sets pending[i].
  - acc_i clears pending[i].
  - rise[i] and acc_i in the same cycle: pending[i] stays 1 (the new event survives), no overflow.
- Overflow:
  - overflow[i] is set when rise[i] & pending[i] & ~acc_i.
  - clr_ovf clears all bits.
  - Set and clr_ovf in the same cycle: set wins for that bit.
- FSM, two states:
  - IDLE: ev_valid=0. If any pending bit is set, select the first set bit searching from rr_ptr upward with wrap to 0. ev_id <= sel, ev_valid <= 1, go to OFFER. Otherwise stay in IDLE.
  - OFFER: ev_valid=1, and ev_id holds stable while ~ev_ready. On acc: rr_ptr <= (ev_id+1) mod N.
    - If any pending bit other than the accepted one remains, select again from (ev_id+1) mod N using the post-accept pending vector. Load ev_id and stay in OFFER (back-to-back, no bubble).
    - Otherwise ev_valid <= 0 and go to IDLE.
  - Same-channel re-rise at acceptance: the re-armed bit is eligible, but only after all other channels in round-robin order.
- Selection uses registered pending only; a rise in cycle k is not visible to the arbiter until cycle k+1.
- Latency: rise sampled at edge k -> pending[i]=1 after k -> ev_valid=1 after edge k+1 (2 edges, IDLE path).
- Wrap: rr_ptr mod N. For non-power-of-two N, indices ≥ N are never selected.
- en=0 does not cancel pending events or an event already offered.
- Reset mid-offer drops the offered event and all pending events with no acknowledgement.

Test Plan:
- Single event: reset, N=4, raise level[2] and hold. Required: pending=4'b0100 one cycle later, ev_valid=1 and ev_id=2 the next cycle, held while ev_ready=0. Pulse ev_ready, then ev_valid=0 and pending=0. Holding level high produces no second event.
- Round-robin: set pending on channels 0, 1, 3 simultaneously, keep ev_ready=1. Required ids: 0, 1, 3 on consecutive cycles. Then pending 0 and 3 with rr_ptr=2: order 3, 0.
- Overflow: hold ev_ready=0 with channel 1 pending, toggle level[1] 0→1 again. Required: overflow[1]=1, pending[1] still 1, exactly one event delivered. A clr_ovf pulse clears it; clr_ovf in the same cycle as a new overflow leaves the bit at 1.
- Re-arm at accept: rise on channel 0 in the same cycle channel 0 is accepted. Required: pending[0] remains 1, no overflow, and channel 0 is offered again.
- Enable masking: en=0, raise level[3]. Required: no pending bit set. en=1 while level[3] is still high: no event (no new edge).
- Reset mid-operation: ev_valid=1 with two pending channels, assert reset one cycle. Required: all outputs 0 next cycle. Any level high at release produces a fresh event 2 cycles later.
